// File: rtl/fft_out_reorder.sv
// Reorders one bit-reversed FFT output frame into natural bin order.
// A ping-pong buffer lets back-to-back frames stream without gaps.
module fft_out_reorder #(
    parameter int unsigned N     = 64,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned LOGN = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_in,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             enable_out,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic [LOGN-1:0]  out_idx
);

    typedef enum logic {StIdle, StRead} state_e;

    localparam logic [LOGN-1:0] LastIdx = LOGN'(N - 1);

    logic [2*WIDTH-1:0] mem [2*N];
    logic [LOGN-1:0]    wr_cnt;
    logic [LOGN-1:0]    rd_cnt;
    logic               wr_bank;
    logic               rd_bank;
    state_e             state;
    logic               frame_done;
    logic [2*WIDTH-1:0] rd_data;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int i = 0; i < int'(LOGN); i++) begin
            r[i] = v[LOGN-1-i];
        end
        return r;
    endfunction

    assign frame_done = enable_in && (wr_cnt == LastIdx);
    assign rd_data    = mem[{rd_bank, bitrev(rd_cnt)}];

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (enable_in) begin
            mem[{wr_bank, wr_cnt}] <= {in_re, in_im};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt     <= '0;
            wr_bank    <= 1'b0;
            rd_cnt     <= '0;
            rd_bank    <= 1'b0;
            state      <= StIdle;
            enable_out <= 1'b0;
            out_re     <= '0;
            out_im     <= '0;
            out_idx    <= '0;
        end else begin
            // wr_cnt wraps to 0 on frame completion since N is a power of two.
            if (enable_in) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (frame_done) begin
                    wr_bank <= ~wr_bank;
                end
            end else begin
                wr_cnt <= '0;
            end

            case (state)
                StIdle: begin
                    enable_out <= 1'b0;
                    out_re     <= '0;
                    out_im     <= '0;
                    out_idx    <= '0;
                    if (frame_done) begin
                        state   <= StRead;
                        rd_bank <= wr_bank;
                        rd_cnt  <= '0;
                    end
                end
                StRead: begin
                    enable_out       <= 1'b1;
                    {out_re, out_im} <= rd_data;
                    out_idx          <= rd_cnt;
                    rd_cnt           <= rd_cnt + 1'b1;
                    // A frame finishing on the last read keeps the stream gapless.
                    if (frame_done) begin
                        rd_bank <= wr_bank;
                        rd_cnt  <= '0;
                    end else if (rd_cnt == LastIdx) begin
                        state <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder at N=64/WIDTH=8 and N=16/WIDTH=12,
// against a frame-level bit-reverse permutation model.
module tb_fft_out_reorder;

    localparam int NA = 64;
    localparam int WA = 8;
    localparam int LA = 6;
    localparam int NB = 16;
    localparam int WB = 12;
    localparam int LB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic          rst_n_a = 1'b1;
    logic          enable_in_a = 1'b0;
    logic [WA-1:0] in_re_a = '0;
    logic [WA-1:0] in_im_a = '0;
    logic          enable_out_a;
    logic [WA-1:0] out_re_a;
    logic [WA-1:0] out_im_a;
    logic [LA-1:0] out_idx_a;

    logic          rst_n_b = 1'b1;
    logic          enable_in_b = 1'b0;
    logic [WB-1:0] in_re_b = '0;
    logic [WB-1:0] in_im_b = '0;
    logic          enable_out_b;
    logic [WB-1:0] out_re_b;
    logic [WB-1:0] out_im_b;
    logic [LB-1:0] out_idx_b;

    fft_out_reorder #(.N(NA), .WIDTH(WA)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n_a),
        .enable_in  (enable_in_a),
        .in_re      (in_re_a),
        .in_im      (in_im_a),
        .enable_out (enable_out_a),
        .out_re     (out_re_a),
        .out_im     (out_im_a),
        .out_idx    (out_idx_a)
    );

    fft_out_reorder #(.N(NB), .WIDTH(WB)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n_b),
        .enable_in  (enable_in_b),
        .in_re      (in_re_b),
        .in_im      (in_im_b),
        .enable_out (enable_out_b),
        .out_re     (out_re_b),
        .out_im     (out_im_b),
        .out_idx    (out_idx_b)
    );

    // Reference model: collect consecutive accepted samples; a run reaching N
    // schedules the whole frame, permuted, against the edges it must appear after.
    logic [2*WA-1:0] fifo_a[$];
    logic [2*WB-1:0] fifo_b[$];
    logic [31:0]     exp_a[int];
    logic [31:0]     exp_b[int];

    function automatic int brev(input int v, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) begin
            if (v[i]) r = r | (1 << (bits - 1 - i));
        end
        return r;
    endfunction

    // Called at a negedge: the sample is captured on edge ecnt+1, so bin k
    // of a completed frame is visible after edge ecnt+2+k.
    task automatic drive_a(input logic en, input logic [WA-1:0] re, input logic [WA-1:0] im);
        enable_in_a = en;
        in_re_a     = re;
        in_im_a     = im;
        if (!en) begin
            fifo_a.delete();
        end else begin
            fifo_a.push_back({re, im});
            if (fifo_a.size() == NA) begin
                for (int k = 0; k < NA; k++)
                    exp_a[ecnt + 2 + k] = 32'({1'b1, LA'(k), fifo_a[brev(k, LA)]});
                fifo_a.delete();
            end
        end
    endtask

    task automatic drive_b(input logic en, input logic [WB-1:0] re, input logic [WB-1:0] im);
        enable_in_b = en;
        in_re_b     = re;
        in_im_b     = im;
        if (!en) begin
            fifo_b.delete();
        end else begin
            fifo_b.push_back({re, im});
            if (fifo_b.size() == NB) begin
                for (int k = 0; k < NB; k++)
                    exp_b[ecnt + 2 + k] = 32'({1'b1, LB'(k), fifo_b[brev(k, LB)]});
                fifo_b.delete();
            end
        end
    endtask

    function automatic logic [31:0] expect_a();
        return exp_a.exists(ecnt) ? exp_a[ecnt] : 32'd0;
    endfunction

    function automatic logic [31:0] expect_b();
        return exp_b.exists(ecnt) ? exp_b[ecnt] : 32'd0;
    endfunction

    function automatic logic [31:0] got_a();
        return 32'({enable_out_a, out_idx_a, out_re_a, out_im_a});
    endfunction

    function automatic logic [31:0] got_b();
        return 32'({enable_out_b, out_idx_b, out_re_b, out_im_b});
    endfunction

    task automatic test_reset();
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        #2;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        #1;
        n_tests++;
        if (got_a() !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_async_a got=%h exp=0", got_a());
        end
        n_tests++;
        if (got_b() !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_async_b got=%h exp=0", got_b());
        end
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (got_a() !== 32'd0 || got_b() !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_hold got_a=%h got_b=%h exp=0", got_a(), got_b());
            end
            drive_a(1'b0, '0, '0);
            drive_b(1'b0, '0, '0);
        end
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
    endtask

    task automatic test_single_frame();
        int hi = 0;
        for (int c = 0; c < 2 * NA + 8; c++) begin
            @(negedge clk);
            n_tests++;
            if (got_a() !== expect_a()) begin
                n_fail++;
                $display("FAIL single_frame edge=%0d got=%h exp=%h", ecnt, got_a(), expect_a());
            end
            if (enable_out_a) begin
                hi++;
                n_tests++;
                if (out_re_a !== WA'(out_idx_a) || out_im_a !== WA'(out_idx_a)) begin
                    n_fail++;
                    $display("FAIL single_frame_value idx=%0d re=%0d im=%0d exp=%0d",
                             out_idx_a, out_re_a, out_im_a, out_idx_a);
                end
            end
            if (c < NA) drive_a(1'b1, WA'(brev(c, LA)), WA'(brev(c, LA)));
            else        drive_a(1'b0, '0, '0);
        end
        n_tests++;
        if (hi != NA) begin
            n_fail++;
            $display("FAIL single_frame_count got=%0d exp=%0d", hi, NA);
        end
    endtask

    task automatic test_back_to_back();
        int   hi = 0;
        int   runs = 0;
        logic prev = 1'b0;
        for (int c = 0; c < 5 * NA + 8; c++) begin
            @(negedge clk);
            n_tests++;
            if (got_a() !== expect_a()) begin
                n_fail++;
                $display("FAIL back_to_back edge=%0d got=%h exp=%h", ecnt, got_a(), expect_a());
            end
            if (enable_out_a) hi++;
            if (enable_out_a && !prev) runs++;
            prev = enable_out_a;
            if (c < 4 * NA) drive_a(1'b1, WA'($urandom), WA'(c / NA));
            else            drive_a(1'b0, '0, '0);
        end
        n_tests++;
        if (hi != 4 * NA || runs != 1) begin
            n_fail++;
            $display("FAIL back_to_back_stream got=%0d/%0d runs exp=%0d/1", hi, runs, 4 * NA);
        end
    endtask

    task automatic test_partial_abort();
        int hi = 0;
        for (int c = 0; c < 41 + 2 * NA + 8; c++) begin
            @(negedge clk);
            n_tests++;
            if (got_a() !== expect_a()) begin
                n_fail++;
                $display("FAIL partial_abort edge=%0d got=%h exp=%h", ecnt, got_a(), expect_a());
            end
            if (enable_out_a) hi++;
            if (c < 40 || (c >= 41 && c < 41 + NA)) drive_a(1'b1, WA'($urandom), WA'($urandom));
            else                                    drive_a(1'b0, '0, '0);
        end
        n_tests++;
        if (hi != NA) begin
            n_fail++;
            $display("FAIL partial_abort_count got=%0d exp=%0d", hi, NA);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] e;
        logic        found = 1'b0;
        int          hi = 0;
        for (int c = 0; c < 3 * NA; c++) begin
            @(negedge clk);
            n_tests++;
            if (got_a() !== expect_a()) begin
                n_fail++;
                $display("FAIL reset_mid_read_pre edge=%0d got=%h exp=%h", ecnt, got_a(), expect_a());
            end
            e = expect_a();
            if (e[22] && e[21:16] == 6'd20) begin
                found = 1'b1;
                break;
            end
            if (c < NA) drive_a(1'b1, WA'($urandom), WA'($urandom));
            else        drive_a(1'b0, '0, '0);
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL reset_mid_read_timeout got=bin20 missing exp=bin20 seen");
        end
        #2;
        rst_n_a = 1'b0;
        exp_a.delete();
        fifo_a.delete();
        #1;
        n_tests++;
        if (got_a() !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_read_async got=%h exp=0", got_a());
        end
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (got_a() !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_mid_read_hold got=%h exp=0", got_a());
            end
            drive_a(1'b0, '0, '0);
        end
        rst_n_a = 1'b1;
        for (int c = 0; c < 2 * NA + 8; c++) begin
            @(negedge clk);
            n_tests++;
            if (got_a() !== expect_a()) begin
                n_fail++;
                $display("FAIL reset_mid_read_post edge=%0d got=%h exp=%h", ecnt, got_a(), expect_a());
            end
            if (enable_out_a) hi++;
            if (c < NA) drive_a(1'b1, WA'($urandom), WA'($urandom));
            else        drive_a(1'b0, '0, '0);
        end
        n_tests++;
        if (hi != NA) begin
            n_fail++;
            $display("FAIL reset_mid_read_count got=%0d exp=%0d", hi, NA);
        end
    endtask

    task automatic test_rand_n16();
        int            hi = 0;
        logic [WB-1:0] re;
        logic [WB-1:0] im;
        for (int c = 0; c < 4 * NB + 8; c++) begin
            @(negedge clk);
            n_tests++;
            if (got_b() !== expect_b()) begin
                n_fail++;
                $display("FAIL rand_n16 edge=%0d got=%h exp=%h", ecnt, got_b(), expect_b());
            end
            if (enable_out_b) hi++;
            re = WB'($urandom);
            im = WB'($urandom);
            if (c % NB == 0) begin
                re = 12'h7FF;
                im = 12'h800;
            end else if (c % NB == 1) begin
                re = 12'h800;
                im = 12'h7FF;
            end
            if (c < 3 * NB) drive_b(1'b1, re, im);
            else            drive_b(1'b0, '0, '0);
        end
        n_tests++;
        if (hi != 3 * NB) begin
            n_fail++;
            $display("FAIL rand_n16_count got=%0d exp=%0d", hi, 3 * NB);
        end
    endtask

    task automatic test_idle_gaps();
        int   hi = 0;
        int   runs = 0;
        logic prev = 1'b0;
        for (int c = 0; c < 3 * (NB + 10) + NB + 8; c++) begin
            @(negedge clk);
            n_tests++;
            if (got_b() !== expect_b()) begin
                n_fail++;
                $display("FAIL idle_gaps edge=%0d got=%h exp=%h", ecnt, got_b(), expect_b());
            end
            if (enable_out_b && !prev) begin
                runs++;
                n_tests++;
                if (out_idx_b !== '0) begin
                    n_fail++;
                    $display("FAIL idle_gaps_restart got=%0d exp=0", out_idx_b);
                end
            end
            if (enable_out_b) hi++;
            prev = enable_out_b;
            if (c < 3 * (NB + 10) && (c % (NB + 10)) < NB)
                drive_b(1'b1, WB'($urandom), WB'($urandom));
            else
                drive_b(1'b0, '0, '0);
        end
        n_tests++;
        if (hi != 3 * NB || runs != 3) begin
            n_fail++;
            $display("FAIL idle_gaps_frames got=%0d/%0d runs exp=%0d/3", hi, runs, 3 * NB);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_partial_abort();
        test_reset_mid_read();
        test_rand_n16();
        test_idle_gaps();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
